// File: rtl/s2mm_job_sched.sv
// Descriptor queue plus launcher for an ap_ctrl_hs S2MM kernel: runs one job at a time
// and returns a completion record {tid, size, err} for each popped descriptor.
module s2mm_job_sched #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [63:0]      desc_mem,
  input  logic [31:0]      desc_size,
  input  logic [7:0]       desc_tdest,
  output logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_ready,
  input  logic             ap_idle,
  output logic [63:0]      mem_V,
  output logic [31:0]      size_V,
  output logic [7:0]       tdest_V,
  input  logic [7:0]       tid_V,
  input  logic             tid_V_ap_vld,
  output logic             cmp_valid,
  input  logic             cmp_ready,
  output logic [7:0]       cmp_tid,
  output logic [31:0]      cmp_size,
  output logic             cmp_err,
  output logic             busy,
  output logic [LVL_W-1:0] qlevel
);

  localparam int PTR_W = LVL_W - 1;

  typedef enum logic [1:0] {IDLE, START, RUN, CMPL} state_t;

  state_t           state;
  logic [63:0]      q_mem   [DEPTH];
  logic [31:0]      q_size  [DEPTH];
  logic [7:0]       q_tdest [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             head_zero;

  // Ready is gated by reset so the host sees back-pressure for the whole reset pulse.
  assign desc_ready = ~ARESET & (qlevel != LVL_W'(DEPTH));
  assign push       = desc_valid & desc_ready;
  assign pop        = (state == IDLE) & (qlevel != '0) & ap_idle;
  assign head_zero  = (q_size[rd_ptr] == '0);
  assign busy       = (state != IDLE);

  // NOTE: the queue storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge ACLK) begin
    if (push) begin
      q_mem[wr_ptr]   <= desc_mem;
      q_size[wr_ptr]  <= desc_size;
      q_tdest[wr_ptr] <= desc_tdest;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      qlevel    <= '0;
      ap_start  <= 1'b0;
      mem_V     <= '0;
      size_V    <= '0;
      tdest_V   <= '0;
      cmp_valid <= 1'b0;
      cmp_tid   <= '0;
      cmp_size  <= '0;
      cmp_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      qlevel <= qlevel + LVL_W'(push) - LVL_W'(pop);

      // TID capture is open only while the kernel owns the job; the last one wins.
      if ((state == START || state == RUN) && tid_V_ap_vld) cmp_tid <= tid_V;

      case (state)
        IDLE: begin
          if (pop) begin
            mem_V    <= q_mem[rd_ptr];
            size_V   <= q_size[rd_ptr];
            tdest_V  <= q_tdest[rd_ptr];
            cmp_size <= q_size[rd_ptr];
            cmp_err  <= head_zero;
            cmp_tid  <= '0;
            if (head_zero) begin
              cmp_valid <= 1'b1;
              state     <= CMPL;
            end else begin
              state <= START;
            end
          end
        end
        START: begin
          // Arguments settle for one cycle before ap_start rises.
          if (!ap_start) begin
            ap_start <= 1'b1;
          end else if (ap_ready) begin
            ap_start <= 1'b0;
            if (ap_done) begin
              cmp_valid <= 1'b1;
              state     <= CMPL;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (ap_done) begin
            cmp_valid <= 1'b1;
            state     <= CMPL;
          end
        end
        CMPL: begin
          if (cmp_ready) begin
            cmp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/s2mm_job_sched.md
S2MM_JOB_SCHED -- requirements
Module: s2mm_job_sched

Interface
REQ-001 Parameter DEPTH, default 4: descriptor queue depth, power of two, minimum 2.
REQ-002 Parameter LVL_W, default 3: width of qlevel, equal to clog2(DEPTH)+1.
REQ-003 Port ACLK, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port ARESET, input, 1: reset, asynchronous and active-high.
REQ-005 Port desc_valid, input, 1: the host presents a descriptor.
REQ-006 Port desc_ready, output, 1: the queue accepts a descriptor.
REQ-007 Port desc_mem, input, 64: destination buffer address.
REQ-008 Port desc_size, input, 32: transfer size.
REQ-009 Port desc_tdest, input, 8: TDEST value for the kernel.
REQ-010 Port ap_start, output, 1: kernel start, ap_ctrl_hs protocol.
REQ-011 Ports ap_done, ap_ready and ap_idle, inputs, 1 bit each: kernel status.
REQ-012 Ports mem_V (output, 64), size_V (output, 32) and tdest_V (output, 8): kernel arguments.
REQ-013 Ports tid_V (input, 8) and tid_V_ap_vld (input, 1): kernel TID output and its valid.
REQ-014 Port cmp_valid, output, 1: completion record valid.
REQ-015 Port cmp_ready, input, 1: completion record accepted.
REQ-016 Ports cmp_tid (output, 8), cmp_size (output, 32) and cmp_err (output, 1): completion record fields.
REQ-017 Ports busy (output, 1) and qlevel (output, LVL_W): status.

Function
REQ-018 The queue shall be a DEPTH-entry FIFO of {mem, size, tdest} entries.
REQ-019 desc_ready shall equal not-full, with no bypass; a push occurs on desc_valid & desc_ready.
REQ-020 On a push and a pop in the same cycle, qlevel shall be unchanged; read and write pointers shall wrap modulo DEPTH.
REQ-021 qlevel shall be the registered occupancy, in the range 0..DEPTH.
REQ-022 The FSM shall have exactly four states: IDLE, START, RUN and CMPL.
REQ-023 IDLE: when qlevel>0 and ap_idle=1, the FSM shall pop the head, register it into mem_V/size_V/tdest_V, clear the tid capture, and go to START next cycle.
REQ-024 IDLE with a head whose size is 0: the FSM shall pop it, shall not pulse ap_start, and shall go to CMPL with cmp_err=1, cmp_tid=0 and cmp_size=0.
REQ-025 START: ap_start shall be 1 and held until ap_ready=1, then the FSM shall go to RUN, or to CMPL if ap_done=1 in the same cycle.
REQ-026 RUN: ap_start shall be 0; on ap_done=1 the FSM shall go to CMPL.
REQ-027 In START or RUN, tid_V_ap_vld=1 shall capture tid_V; the last capture wins; if no capture occurs, cmp_tid shall be 0.
REQ-028 CMPL: cmp_valid shall be 1, and cmp_tid, cmp_size (equal to the launched size_V) and cmp_err shall be stable until cmp_ready=1, then the FSM shall go to IDLE.
REQ-029 For a non-zero-size job, cmp_err shall be 0.
REQ-030 ap_done outside START/RUN shall be ignored; ap_ready outside START shall be ignored.
REQ-031 mem_V, size_V and tdest_V shall change only on a pop and shall hold between jobs.
REQ-032 busy shall be 1 in START, RUN and CMPL.
REQ-033 Latency: a push into an empty queue at edge N, with ap_idle=1, shall give ap_start=1 after edge N+2.
REQ-034 Pushes shall be accepted in every FSM state while the queue is not full.
REQ-035 There shall be one job in flight at most; no new pop shall occur before the CMPL handshake completes.

Reset
REQ-036 ARESET shall act immediately, independent of ACLK.
REQ-037 ARESET shall set: FSM=IDLE, queue empty, qlevel=0, desc_ready=0 while ARESET is asserted and 1 after release, ap_start=0, mem_V/size_V/tdest_V=0, cmp_valid=0, cmp_tid/cmp_size/cmp_err=0 and busy=0.
REQ-038 Reset mid-job shall discard the queue and the in-flight job, and shall generate no completion.

Verification
REQ-039 Single job: push {mem=0x1_0000_0000, size=0x400, tdest=3}; ap_ready one cycle after ap_start; ap_done 5 cycles later with tid_V=0x07 valid -> mem_V/size_V/tdest_V match; ap_start is high exactly until ap_ready; one completion {tid=0x07, size=0x400, err=0}.
REQ-040 Full queue: push 5 descriptors back-to-back with the kernel stalled (ap_idle=0) -> 4 accepted, desc_ready=0 on the 5th, qlevel=4; release the kernel -> completions in push order.
REQ-041 Zero size: push size=0 followed by size=0x10 -> first completion has err=1 and tid=0 with no ap_start pulse; the second job launches normally.
REQ-042 Same-cycle ready/done: ap_ready and ap_done in the same cycle -> START goes directly to CMPL; exactly one completion.
REQ-043 Backpressure and reset: hold cmp_ready=0 for 10 cycles -> completion fields stable and no new ap_start; then assert ARESET asynchronously in RUN -> all outputs are at reset values before the next edge, and no completion follows.
